// File: rtl/if_stage_btb.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_btb
// Brief    : Fetch stage with PC, IF/ID register and a 4-entry fully
//            associative BTB using 2-bit saturating counters.
// Revision : 1.0
// ============================================================================
module if_stage_btb #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          BTB_ENTRIES = 4,
   parameter logic [15:0] NOP_WORD    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        res_valid,
   input  logic [15:0] res_pc,
   input  logic        res_taken,
   input  logic [15:0] res_target,
   input  logic        res_mispredict,
   input  logic [15:0] res_correct_pc,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic        ifid_pred_taken,
   output logic [15:0] ifid_pred_target,
   output logic [15:0] pc
);

   localparam int C_PTR_W = $clog2(BTB_ENTRIES);

   logic               btb_valid_q  [BTB_ENTRIES];
   logic [15:0]        btb_tag_q    [BTB_ENTRIES];
   logic [15:0]        btb_target_q [BTB_ENTRIES];
   logic [1:0]         btb_ctr_q    [BTB_ENTRIES];
   logic [C_PTR_W-1:0] ptr_q;

   logic [15:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [15:0] ifid_instr_q, ifid_instr_d;
   logic [15:0] ifid_pc_q, ifid_pc_d;
   logic        ifid_pt_q, ifid_pt_d;
   logic [15:0] ifid_ptgt_q, ifid_ptgt_d;

   logic               w_hit, w_upd_hit, w_pred_taken;
   logic [C_PTR_W-1:0] w_hit_idx, w_upd_idx;
   logic [15:0]        w_pred_target;

   // Fetch lookup and resolution lookup see the same pre-update contents.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_upd_hit = 1'b0;
      w_upd_idx = '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
         if (btb_valid_q[i] && (btb_tag_q[i] == pc_q)) begin
            w_hit     = 1'b1;
            w_hit_idx = C_PTR_W'(i);
         end
         if (btb_valid_q[i] && (btb_tag_q[i] == res_pc)) begin
            w_upd_hit = 1'b1;
            w_upd_idx = C_PTR_W'(i);
         end
      end
      w_pred_taken  = w_hit & btb_ctr_q[w_hit_idx][1];
      w_pred_target = w_pred_taken ? btb_target_q[w_hit_idx] : 16'h0000;
   end

   always_comb begin
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pt_d    = ifid_pt_q;
      ifid_ptgt_d  = ifid_ptgt_q;
      if (res_valid && res_mispredict) begin
         pc_d         = res_correct_pc;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_WORD;
      end else if (!stall) begin
         pc_d         = w_pred_taken ? w_pred_target : pc_q + 16'd1;
         ifid_valid_d = 1'b1;
         ifid_instr_d = imem_data;
         ifid_pc_d    = pc_q;
         ifid_pt_d    = w_pred_taken;
         ifid_ptgt_d  = w_pred_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_WORD;
         ifid_pc_q    <= 16'h0000;
         ifid_pt_q    <= 1'b0;
         ifid_ptgt_q  <= 16'h0000;
      end else begin
         pc_q         <= pc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pt_q    <= ifid_pt_d;
         ifid_ptgt_q  <= ifid_ptgt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i]  <= 1'b0;
            btb_tag_q[i]    <= 16'h0000;
            btb_target_q[i] <= 16'h0000;
            btb_ctr_q[i]    <= 2'b01;
         end
         ptr_q <= '0;
      end else if (res_valid) begin
         if (w_upd_hit) begin
            if (res_taken) begin
               if (btb_ctr_q[w_upd_idx] != 2'b11)
                  btb_ctr_q[w_upd_idx] <= btb_ctr_q[w_upd_idx] + 2'd1;
               btb_target_q[w_upd_idx] <= res_target;
            end else if (btb_ctr_q[w_upd_idx] != 2'b00) begin
               btb_ctr_q[w_upd_idx] <= btb_ctr_q[w_upd_idx] - 2'd1;
            end
         end else if (res_taken) begin
            btb_valid_q[ptr_q]  <= 1'b1;
            btb_tag_q[ptr_q]    <= res_pc;
            btb_target_q[ptr_q] <= res_target;
            btb_ctr_q[ptr_q]    <= 2'b10;
            ptr_q               <= ptr_q + 1'b1;
         end
      end
   end

   assign pc               = pc_q;
   assign imem_addr        = pc_q;
   assign ifid_valid       = ifid_valid_q;
   assign ifid_instr       = ifid_instr_q;
   assign ifid_pc          = ifid_pc_q;
   assign ifid_pred_taken  = ifid_pt_q;
   assign ifid_pred_target = ifid_ptgt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage_btb
// Brief    : Directed self-checking bench for if_stage_btb.
// Revision : 1.0
// ============================================================================
module tb_if_stage_btb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        res_valid;
   logic [15:0] res_pc;
   logic        res_taken;
   logic [15:0] res_target;
   logic        res_mispredict;
   logic [15:0] res_correct_pc;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic        ifid_pred_taken;
   logic [15:0] ifid_pred_target;
   logic [15:0] pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // IM[0]=0245, IM[1]=06C2, everything else addr ^ A500.
   assign imem_data = (imem_addr == 16'd0) ? 16'h0245 :
                      (imem_addr == 16'd1) ? 16'h06C2 : (imem_addr ^ 16'hA500);

   if_stage_btb dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
      .res_target(res_target), .res_mispredict(res_mispredict),
      .res_correct_pc(res_correct_pc),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
      .ifid_pred_taken(ifid_pred_taken), .ifid_pred_target(ifid_pred_target),
      .pc(pc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_res();
      res_valid      = 1'b0;
      res_pc         = 16'hF000;
      res_taken      = 1'b0;
      res_target     = 16'h0000;
      res_mispredict = 1'b0;
      res_correct_pc = 16'h0000;
   endtask

   // Redirect through a mispredict whose res_pc never lives in the BTB.
   task automatic redirect(input logic [15:0] target);
      res_valid      = 1'b1;
      res_pc         = 16'hF000;
      res_taken      = 1'b0;
      res_mispredict = 1'b1;
      res_correct_pc = target;
      tick();
      idle_res();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stall = 1'b0;
      idle_res();
      repeat (3) tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", ifid_instr); end
      checks++; if (dut.btb_ctr_q[2] !== 2'b01) begin errors++; $display("FAIL reset_ctr got %b exp 01", dut.btb_ctr_q[2]); end
      rst_n = 1'b1;
      tick();
      checks++; if (ifid_instr !== 16'h0245) begin errors++; $display("FAIL first_instr got %h exp 0245", ifid_instr); end
      checks++; if (ifid_pc !== 16'h0000) begin errors++; $display("FAIL first_pc got %h exp 0000", ifid_pc); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", ifid_valid); end
      tick();
      checks++; if (ifid_instr !== 16'h06C2) begin errors++; $display("FAIL second_instr got %h exp 06C2", ifid_instr); end
      checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL second_pc got %h exp 0002", pc); end
   endtask

   task automatic test_stall();
      repeat (3) tick();
      checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL pre_stall_pc got %h exp 0005", pc); end
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL stall_pc got %h exp 0005", pc); end
         checks++; if (ifid_pc !== 16'h0004 || ifid_instr !== 16'hA504) begin errors++; $display("FAIL stall_ifid got %h/%h exp 0004/A504", ifid_pc, ifid_instr); end
      end
      stall = 1'b0;
      tick();
      checks++; if (ifid_pc !== 16'h0005 || ifid_instr !== 16'hA505) begin errors++; $display("FAIL resume_ifid got %h/%h exp 0005/A505", ifid_pc, ifid_instr); end
      checks++; if (pc !== 16'h0006) begin errors++; $display("FAIL resume_pc got %h exp 0006", pc); end
   endtask

   task automatic test_btb_alloc();
      res_valid  = 1'b1;
      res_pc     = 16'd16;
      res_taken  = 1'b1;
      res_target = 16'd10;
      tick();
      idle_res();
      checks++; if (dut.btb_valid_q[0] !== 1'b1 || dut.btb_tag_q[0] !== 16'd16) begin errors++; $display("FAIL alloc_tag got %b/%h exp 1/0010", dut.btb_valid_q[0], dut.btb_tag_q[0]); end
      checks++; if (dut.btb_target_q[0] !== 16'd10 || dut.btb_ctr_q[0] !== 2'b10) begin errors++; $display("FAIL alloc_entry got %h/%b exp 000a/10", dut.btb_target_q[0], dut.btb_ctr_q[0]); end
      redirect(16'd16);
      checks++; if (pc !== 16'd16 || ifid_valid !== 1'b0) begin errors++; $display("FAIL redirect16 got %h/%b exp 0010/0", pc, ifid_valid); end
      tick();
      checks++; if (ifid_pred_taken !== 1'b1 || ifid_pred_target !== 16'd10) begin errors++; $display("FAIL predict got %b/%h exp 1/000a", ifid_pred_taken, ifid_pred_target); end
      checks++; if (ifid_pc !== 16'd16 || pc !== 16'd10) begin errors++; $display("FAIL predict_pc got %h/%h exp 0010/000a", ifid_pc, pc); end
      tick();
      checks++; if (ifid_pred_taken !== 1'b0 || ifid_pred_target !== 16'd0 || pc !== 16'd11) begin errors++; $display("FAIL no_pred got %b/%h/%h exp 0/0000/000b", ifid_pred_taken, ifid_pred_target, pc); end
   endtask

   task automatic test_mispredict();
      stall = 1'b1;
      redirect(16'd17);
      stall = 1'b0;
      checks++; if (pc !== 16'd17) begin errors++; $display("FAIL mispredict_pc got %h exp 0011", pc); end
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin errors++; $display("FAIL mispredict_bubble got %b/%h exp 0/0000", ifid_valid, ifid_instr); end
   endtask

   task automatic test_counter_rr();
      for (int i = 0; i < 3; i++) begin
         res_valid = 1'b1; res_pc = 16'd16; res_taken = 1'b1; res_target = 16'd10;
         tick();
      end
      idle_res();
      checks++; if (dut.btb_ctr_q[0] !== 2'b11) begin errors++; $display("FAIL ctr_sat_hi got %b exp 11", dut.btb_ctr_q[0]); end
      for (int i = 0; i < 2; i++) begin
         res_valid = 1'b1; res_pc = 16'd16; res_taken = 1'b0;
         tick();
      end
      idle_res();
      checks++; if (dut.btb_ctr_q[0] !== 2'b01) begin errors++; $display("FAIL ctr_dec got %b exp 01", dut.btb_ctr_q[0]); end
      redirect(16'd16);
      tick();
      checks++; if (ifid_pred_taken !== 1'b0 || pc !== 16'd17) begin errors++; $display("FAIL weak_nt got %b/%h exp 0/0011", ifid_pred_taken, pc); end
      for (int i = 0; i < 5; i++) begin
         res_valid = 1'b1; res_pc = 16'h0100 + 16'(i); res_taken = 1'b1; res_target = 16'h0200 + 16'(i);
         tick();
      end
      idle_res();
      checks++; if (dut.btb_tag_q[1] !== 16'h0104 || dut.btb_target_q[1] !== 16'h0204) begin errors++; $display("FAIL rr_entry1 got %h/%h exp 0104/0204", dut.btb_tag_q[1], dut.btb_target_q[1]); end
      checks++; if (dut.btb_tag_q[0] !== 16'h0103 || dut.btb_tag_q[2] !== 16'h0101 || dut.btb_tag_q[3] !== 16'h0102) begin errors++; $display("FAIL rr_others got %h/%h/%h exp 0103/0101/0102", dut.btb_tag_q[0], dut.btb_tag_q[2], dut.btb_tag_q[3]); end
      redirect(16'h0104);
      tick();
      checks++; if (ifid_pred_taken !== 1'b1 || pc !== 16'h0204) begin errors++; $display("FAIL rr_predict got %b/%h exp 1/0204", ifid_pred_taken, pc); end
   endtask

   task automatic test_pc_wrap();
      redirect(16'hFFFF);
      tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
      checks++; if (ifid_pc !== 16'hFFFF || ifid_instr !== 16'h5AFF) begin errors++; $display("FAIL wrap_ifid got %h/%h exp FFFF/5AFF", ifid_pc, ifid_instr); end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 16'h0000 || ifid_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b exp 0000/0", pc, ifid_valid); end
      checks++; if (dut.btb_valid_q[1] !== 1'b0 || dut.ptr_q !== 2'd0) begin errors++; $display("FAIL async_btb got %b/%0d exp 0/0", dut.btb_valid_q[1], dut.ptr_q); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (ifid_instr !== 16'h0245 || pc !== 16'h0001) begin errors++; $display("FAIL post_reset got %h/%h exp 0245/0001", ifid_instr, pc); end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_btb_alloc();
      test_mispredict();
      test_counter_rr();
      test_pc_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_stage_btb.md
Name: if_stage_btb

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor. Sits directly upstream of decode.
- Holds the PC and drives the instruction-memory address. Registers the fetched word into the IF/ID pipeline register.
- Predicts branches with a 4-entry fully associative branch target buffer (BTB); each entry has a 2-bit saturating counter.
- Accepts stall requests from the hazard unit and redirect/update information from branch resolution in execute.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BTB_ENTRIES, 4, number of BTB entries (fixed at 4; pointer is 2 bits).
- NOP_WORD, 16'h0000, instruction word placed in IF/ID when the slot is a bubble.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- imem_addr  output  16  instruction memory word address (equals pc).
- imem_data  input  16  instruction word, combinational read of IM[imem_addr].
- res_valid  input  1  a branch/jump resolved in execute this cycle.
- res_pc  input  16  PC of the resolved branch.
- res_taken  input  1  actual outcome.
- res_target  input  16  actual taken target.
- res_mispredict  input  1  prediction was wrong; redirect required.
- res_correct_pc  input  16  PC to fetch after a mispredict.
- ifid_valid  output  1  IF/ID slot holds a real instruction.
- ifid_instr  output  16  fetched instruction.
- ifid_pc  output  16  PC of ifid_instr.
- ifid_pred_taken  output  1  BTB predicted taken for this instruction.
- ifid_pred_target  output  16  predicted target (0 when not taken).
- pc  output  16  current fetch PC, exposed for bench monitoring.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC.
  - ifid_valid = 0, ifid_instr = NOP_WORD, ifid_pc = 0, ifid_pred_taken = 0, ifid_pred_target = 0.
  - All BTB valid bits = 0, all counters = 2'b01, replacement pointer = 0.
  - Release is synchronous in effect: the first fetch of RESET_PC is registered on the first rising edge with rst_n high.
- Lookup, combinational on pc:
  - Hit when an entry has valid=1 and tag==pc.
  - Multiple hits cannot occur, because allocation checks for a hit first.
  - pred_taken = hit AND counter[1]; pred_target = entry target.
- Next-PC priority, highest first:
  1. res_valid & res_mispredict: pc <= res_correct_pc; ifid_valid <= 0; ifid_instr <= NOP_WORD.
  2. stall: pc and all ifid_* hold.
  3. pred_taken: pc <= pred_target; IF/ID <= {1, imem_data, pc, 1, pred_target}.
  4. Otherwise: pc <= pc+1, wrapping 16'hFFFF -> 16'h0000; IF/ID <= {1, imem_data, pc, 0, 0}.
- Redirect beats stall when both are high. Fetch latency is 1 cycle, with no bubble on a correct prediction. A mispredict costs exactly one IF/ID bubble from this stage.
- BTB update, on a rising edge when res_valid=1. It is independent of stall and of redirect.
  - Entry hit on res_pc:
    - Taken: counter increments, saturating at 2'b11, and target <= res_target.
    - Not taken: counter decrements, saturating at 2'b00.
  - Miss and res_taken=1: allocate the entry at the pointer with valid=1, tag=res_pc, target=res_target, counter=2'b10. Pointer increments mod 4.
  - Miss and res_taken=0: no change.
- Same-cycle lookup and update of the same PC: the lookup uses pre-update contents (no bypass).
- Reset mid-operation discards in-flight IF/ID contents and all BTB state immediately.

Test Plan:
- Reset: hold rst_n=0 across 3 edges, then release with IM[0]=16'h0245, IM[1]=16'h06C2. Required: pc=0 during reset, ifid_valid=0. After the first edge, ifid_instr=0245 and ifid_pc=0. After the second edge, ifid_instr=06C2 and pc=2.
- Sequential stall: assert stall for 2 cycles while pc=5. Required: pc stays 5 and ifid_* are unchanged. On deassert, fetch resumes at 5.
- BTB allocate and predict:
  - Drive res_valid=1, res_pc=16, res_taken=1, res_target=10.
  - Required: entry 0 = {1, 16, 10, 2'b10}.
  - Next fetch at pc=16: ifid_pred_taken=1, following pc=10.
- Mispredict redirect: with pc=11, drive res_mispredict=1, res_correct_pc=17 together with stall=1. Required: pc=17, ifid_valid=0, ifid_instr=0000 on the next edge.
- Counter saturation and round-robin:
  - Apply 3 taken updates to pc 16 (counter reaches 11 and stays 11).
  - Then apply 2 not-taken updates (counter 01; a fetch at 16 predicts not taken, pc -> 17).
  - Then allocate 5 new taken PCs. Required: the fifth overwrites entry 1, since the pointer wraps 3 -> 0 and pc 16 sits in entry 0.
- PC wrap: force pc=16'hFFFF with no hit. Required: next pc=16'h0000, ifid_pc=16'hFFFF.
